// File: rtl/pin_handshake_rx.sv
// pin_handshake_rx: 4-phase req/ack pin receiver feeding a first-word-fall-through FIFO
module pin_handshake_rx #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          pin_data,
    input  logic                       pin_req,
    output logic                       pin_ack,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       err,
    input  logic                       err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] L_FULL = LW'(DEPTH);

    localparam logic [1:0] S_ARM  = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_sync_vld;
    logic [1:0]             r_state;
    logic                   r_ack;
    logic                   r_err;
    logic [DATA_W-1:0]      r_mem [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [LW-1:0]          r_level;

    logic                   w_req_s;
    logic                   w_full;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_abort;
    logic [1:0]             w_state_nxt;

    assign w_req_s    = r_sync[SYNC_STAGES-1];
    assign w_full     = r_level == L_FULL;
    assign w_pop      = out_valid && out_ready;
    assign pin_ack    = r_ack;
    assign err        = r_err;
    assign fifo_level = r_level;
    assign out_valid  = r_level != '0;
    assign out_data   = r_mem[r_rd_ptr];

    // Synchronize pin_req; r_sync_vld marks when req_s reflects the pin rather than reset zeros,
    // so a request held across reset is not mistaken for a released one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync     <= '0;
            r_sync_vld <= '0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], pin_req};
            r_sync_vld <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Handshake FSM next-state, write strobe and abort detection; fullness uses the registered level.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_abort     = 1'b0;
        unique case (r_state)
            S_ARM: begin
                if (r_sync_vld[SYNC_STAGES-1] && !w_req_s)
                    w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (w_req_s) begin
                    w_push      = !w_full;
                    w_state_nxt = w_full ? S_WAIT : S_ACK;
                end
            end
            S_WAIT: begin
                if (!w_req_s) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (!w_full) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                if (!w_req_s)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_ARM;
        endcase
    end

    // State, registered ack (high exactly while in ACK) and sticky error with set-over-clear priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ARM;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_state_nxt == S_ACK;
            r_err   <= w_abort ? 1'b1 : (err_clr ? 1'b0 : r_err);
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_level  <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

    // FIFO storage; pin_data is stable while req is high so it is captured without synchronization.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= pin_data;
    end
endmodule

// File: doc/pin_handshake_rx.md
Name: pin_handshake_rx

Overview:
- Receives bytes from an external host over the dedicated input pins using a 4-phase req/ack handshake.
- Host drives pin_data and pin_req; the block drives pin_ack.
- Captured bytes are buffered in a small first-word-fall-through FIFO and presented to the on-chip logic through a valid/ready stream.
- Sits between the top-level pin wrapper (pin_data on ui_in, pin_req on uio_in[0], pin_ack on uio_out[1]) and the core datapath.

Parameters:
- DATA_W, 8: width of pin_data and out_data.
- DEPTH, 4: FIFO entries. Power of two, at least 2.
- SYNC_STAGES, 2: flops in the pin_req synchronizer, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- pin_data  in  DATA_W  host byte; must be stable whenever pin_req=1.
- pin_req  in  1  host request; asynchronous to clk.
- pin_ack  out  1  acknowledge to host; registered.
- out_data  out  DATA_W  FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head.
- fifo_level  out  clog2(DEPTH)+1  entries held, 0..DEPTH.
- err  out  1  sticky protocol-error flag.
- err_clr  in  1  clears err.

Behaviour:

Reset:
- rst sampled at a clk edge.
- Afterwards: pin_ack=0, out_valid=0, fifo_level=0, err=0, synchronizer flops=0, state=ARM.
- FIFO read and write pointers = 0.

Synchronizer:
- req_s is pin_req after SYNC_STAGES flops. The FSM uses only req_s.
- pin_data is sampled directly, with no synchronizer.

FSM states: ARM, IDLE, WAIT, ACK.
- ARM:
  - Stay while req_s=1; go to IDLE when req_s=0.
  - This prevents a host request left high across a reset from being captured a second time.
- IDLE, req_s=1 and fifo_level<DEPTH:
  - Write pin_data into the FIFO and set pin_ack<=1 on the same edge.
  - Go to ACK.
- IDLE, req_s=1 and fifo_level==DEPTH: go to WAIT. pin_ack stays 0.
- WAIT:
  - fifo_level<DEPTH and req_s=1: write pin_data, pin_ack<=1, go to ACK.
  - req_s=0 (host aborted): set err, go to IDLE, no write.
- ACK:
  - Hold pin_ack=1 until req_s=0.
  - Then pin_ack<=0 and go to IDLE.
- Full check uses the registered fifo_level. A pop in the same cycle does not enable a push in that cycle.

Latency, SYNC_STAGES=2, non-full FIFO:
- pin_req rises before edge E0 and is captured into sync0 at E0.
- req_s=1 after E1.
- Write and pin_ack=1 happen at E2.
- pin_ack falls 3 edges after pin_req falls, by the same path.

FIFO:
- Push occurs only from the FSM write.
- Pop occurs when out_valid && out_ready.
- out_data = mem[rd_ptr], combinational from registered state.
- out_valid = (fifo_level!=0).
- Push and pop in the same cycle: level unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Pop while empty is ignored.
- No overflow is possible: the FSM stalls instead.

err:
- Set on a WAIT abort.
- err_clr clears it, but a set in the same cycle wins.

Reset mid-handshake:
- FIFO contents are discarded and pin_ack drops on the reset edge.
- The FSM enters ARM and waits for req_s=0.

Test Plan:
- Single transfer: pin_data=0xA5, pin_req 0→1 and held, then 0. Required: pin_ack rises exactly 3 clk edges after the req edge; out_valid=1 with out_data=0xA5; fifo_level=1; pin_ack falls 3 edges after pin_req falls.
- Fill and stall, out_ready=0: send 0x01..0x04. Required: fifo_level=4.
  - Fifth request 0x05: pin_ack stays 0 (WAIT).
  - Pulse out_ready for 1 cycle: 0x01 is popped; the next cycle 0x05 is written and pin_ack=1; fifo_level returns to 4.
  - Drain reads 0x02, 0x03, 0x04, 0x05 in order.
- Wrap-around with out_ready=1: stream 10 bytes 0x10..0x19. Required: all are received in order, fifo_level never exceeds 1, err=0.
- Simultaneous push/pop: with level=2 and out_ready=1, align a write edge with a pop. Required: level stays 2 and ordering is preserved.
- Abort: FIFO full, fifth request raised, then pin_req dropped before space frees. Required: err=1, no write, state back to IDLE. err_clr for 1 cycle gives err=0.
- Reset mid-handshake: assert rst while in ACK with pin_req held high. Required: after reset, pin_ack=0, fifo_level=0, and there is no capture until pin_req goes low and then high again. The next byte 0x3C is received exactly once.
